// File: rtl/nnrv_pkg.sv
// Shared types and default parameters for the nnrv fetch front end.
package nnrv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_e;

  localparam int          XLEN_DEF        = 64;
  localparam int          DATA_WIDTH_DEF  = 64;
  localparam int          INSTR_WIDTH_DEF = 32;
  localparam int          DEPTH_DEF       = 4;
  localparam logic [63:0] RESET_PC_DEF    = 64'h0;

endpackage

// File: rtl/nnrv_fifo.sv
// Circular-buffer FIFO with flush; a push into a full queue succeeds only
// when a pop frees a slot in the same cycle.
module nnrv_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is left unreset; count gates visibility of stale entries.
  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nnrv_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory requests feeding an
// instruction queue toward decode, with redirect flush and stale-response drop.
module nnrv_fetch_queue
  import nnrv_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int              INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int              DEPTH       = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_mem_req,
  output logic [XLEN-1:0]        o_mem_addr,
  input  logic                   i_mem_gnt,
  input  logic                   i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
  output logic                   o_id_valid,
  output logic [INSTR_WIDTH-1:0] o_id_instr,
  output logic [XLEN-1:0]        o_id_pc,
  input  logic                   i_id_ready,
  input  logic                   i_redirect,
  input  logic [XLEN-1:0]        i_redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = DATA_WIDTH / 32;
  localparam int QW = INSTR_WIDTH + XLEN;

  fq_state_e              state, state_nxt;
  logic [XLEN-1:0]        pc, pc_nxt, req_addr;
  logic [CW-1:0]          count;
  logic                   push, pop, flush, issue;
  logic [INSTR_WIDTH-1:0] instr_slice;
  logic [QW-1:0]          q_head;
  int unsigned            k;
  logic                   unused_pc_lsbs;

  assign unused_pc_lsbs = ^i_redirect_pc[1:0];

  assign o_mem_addr = pc;
  assign o_mem_req  = (state == IDLE) && (count < CW'(DEPTH)) && !i_redirect;
  assign issue      = o_mem_req && i_mem_gnt;

  // Word lane within the read beat selected by the request address.
  always_comb begin
    k           = 32'((req_addr >> 2) & XLEN'(NW - 1));
    instr_slice = INSTR_WIDTH'(i_mem_rdata >> (32 * k));
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (i_redirect && i_mem_gnt) begin
          state_nxt = DROP;
        end else if (issue) begin
          state_nxt = WAIT;
          pc_nxt    = pc + XLEN'(4);
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_nxt = IDLE;
          push      = !i_redirect;
        end else if (i_redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (i_mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_redirect) pc_nxt = {i_redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (issue) req_addr <= pc;
    end
  end

  // Redirect wins over decode handshake: the flush discards the head anyway.
  assign flush = i_redirect;
  assign pop   = o_id_valid && i_id_ready && !i_redirect;

  nnrv_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_iq (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .wdata ({instr_slice, req_addr}),
    .pop   (pop),
    .flush (flush),
    .rdata (q_head),
    .count (count)
  );

  assign o_id_valid = (count != '0);
  assign o_id_instr = q_head[QW-1:XLEN];
  assign o_id_pc    = q_head[XLEN-1:0];

endmodule

// File: tb/tb_nnrv_fetch_queue.sv
// Directed bench for nnrv_fetch_queue plus a standalone full-queue check of nnrv_fifo.
module tb_nnrv_fetch_queue;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_mem_req;
  logic [63:0] o_mem_addr;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [63:0] i_mem_rdata = '0;
  logic        o_id_valid;
  logic [31:0] o_id_instr;
  logic [63:0] o_id_pc;
  logic        i_id_ready = 1'b1;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_pc = '0;

  logic        f_push = 1'b0, f_pop = 1'b0, f_flush = 1'b0;
  logic [7:0]  f_wdata = '0, f_rdata;
  logic [2:0]  f_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  nnrv_fetch_queue dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_id_valid    (o_id_valid),
    .o_id_instr    (o_id_instr),
    .o_id_pc       (o_id_pc),
    .i_id_ready    (i_id_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  nnrv_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (f_push),
    .wdata (f_wdata),
    .pop   (f_pop),
    .flush (f_flush),
    .rdata (f_rdata),
    .count (f_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Beat for an 8-byte block: low word 0x13000000^base, high word 0x13000000^(base+4).
  function automatic logic [63:0] mkdata(input logic [63:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {32'h1300_0000 ^ (b + 32'd4), 32'h1300_0000 ^ b};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Grant at the current cycle, return data the next cycle.
  task automatic fetch_one(input logic [63:0] addr);
    chk("req", {63'd0, o_mem_req}, 64'd1);
    chk("addr", o_mem_addr, addr);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    #1;
    chk("wait_req", {63'd0, o_mem_req}, 64'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = mkdata(addr);
    step();
    i_mem_rvalid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_valid", {63'd0, o_id_valid}, 64'd0);
    chk("rst_addr", o_mem_addr, 64'h0);
    step();
    i_rst = 1'b0;
    #1;
    chk("rel_req", {63'd0, o_mem_req}, 64'd1);

    // Sequential fetch, each response popped immediately.
    fetch_one(64'h0);
    chk("f0_valid", {63'd0, o_id_valid}, 64'd1);
    chk("f0_pc", o_id_pc, 64'h0);
    chk("f0_instr", {32'd0, o_id_instr}, 64'h1300_0000);
    fetch_one(64'h4);
    chk("f4_pc", o_id_pc, 64'h4);
    chk("f4_instr", {32'd0, o_id_instr}, 64'h1300_0004);
    fetch_one(64'h8);
    chk("f8_instr", {32'd0, o_id_instr}, 64'h1300_0008);
    step();
    chk("drained", {63'd0, o_id_valid}, 64'd0);

    // Fill with decode stalled.
    i_id_ready    = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h0;
    #1;
    chk("redir_req", {63'd0, o_mem_req}, 64'd0);
    step();
    i_redirect = 1'b0;
    #1;
    fetch_one(64'h0);
    fetch_one(64'h4);
    fetch_one(64'h8);
    fetch_one(64'hC);
    chk("full_req", {63'd0, o_mem_req}, 64'd0);
    step();
    chk("full_req2", {63'd0, o_mem_req}, 64'd0);
    i_id_ready = 1'b1;
    #1;
    chk("hd0_pc", o_id_pc, 64'h0);
    chk("hd0_instr", {32'd0, o_id_instr}, 64'h1300_0000);
    step();
    chk("resume_req", {63'd0, o_mem_req}, 64'd1);
    chk("resume_addr", o_mem_addr, 64'h10);
    chk("hd1_pc", o_id_pc, 64'h4);
    chk("hd1_instr", {32'd0, o_id_instr}, 64'h1300_0004);
    step();
    chk("hd2_pc", o_id_pc, 64'h8);
    step();
    chk("hd3_pc", o_id_pc, 64'hC);
    chk("hd3_instr", {32'd0, o_id_instr}, 64'h1300_000C);
    step();
    i_id_ready = 1'b0;
    #1;
    chk("empty", {63'd0, o_id_valid}, 64'd0);

    // Redirect while a response is outstanding.
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt     = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h100;
    #1;
    chk("wr_req", {63'd0, o_mem_req}, 64'd0);
    step();
    i_redirect = 1'b0;
    #1;
    chk("drop_req", {63'd0, o_mem_req}, 64'd0);
    chk("drop_valid", {63'd0, o_id_valid}, 64'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = mkdata(64'h10);
    step();
    i_mem_rvalid = 1'b0;
    #1;
    chk("late_valid", {63'd0, o_id_valid}, 64'd0);
    chk("post_drop_addr", o_mem_addr, 64'h100);
    fetch_one(64'h100);
    chk("r100_valid", {63'd0, o_id_valid}, 64'd1);
    chk("r100_pc", o_id_pc, 64'h100);
    chk("r100_instr", {32'd0, o_id_instr}, 64'h1300_0100);
    fetch_one(64'h104);
    chk("r104_head", o_id_pc, 64'h100);

    // Redirect coincident with a pop: flush wins, target realigned.
    i_id_ready    = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h206;
    step();
    i_redirect = 1'b0;
    #1;
    chk("rp_valid", {63'd0, o_id_valid}, 64'd0);
    chk("rp_req", {63'd0, o_mem_req}, 64'd1);
    chk("rp_addr", o_mem_addr, 64'h204);

    // Reset in WAIT; the late response must be ignored.
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    #1;
    chk("rw_req", {63'd0, o_mem_req}, 64'd0);
    i_rst = 1'b1;
    #1;
    chk("arst_addr", o_mem_addr, 64'h0);
    chk("arst_valid", {63'd0, o_id_valid}, 64'd0);
    step();
    i_rst        = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = mkdata(64'h204);
    step();
    i_mem_rvalid = 1'b0;
    #1;
    chk("stale_valid", {63'd0, o_id_valid}, 64'd0);
    chk("stale_addr", o_mem_addr, 64'h0);
    fetch_one(64'h0);
    chk("rs_pc", o_id_pc, 64'h0);
    chk("rs_instr", {32'd0, o_id_instr}, 64'h1300_0000);

    // Standalone queue: full push+pop keeps count and order.
    for (int i = 0; i < 4; i++) begin
      f_push  = 1'b1;
      f_wdata = 8'hA1 + 8'(i);
      step();
    end
    f_wdata = 8'hFF;
    #1;
    chk("fq_full", {61'd0, f_count}, 64'd4);
    step();
    chk("fq_reject", {61'd0, f_count}, 64'd4);
    chk("fq_head0", {56'd0, f_rdata}, 64'hA1);
    f_pop   = 1'b1;
    f_wdata = 8'hA5;
    step();
    chk("fq_pp_cnt", {61'd0, f_count}, 64'd4);
    chk("fq_pp_head", {56'd0, f_rdata}, 64'hA2);
    f_wdata = 8'hA6;
    step();
    chk("fq_pp_cnt2", {61'd0, f_count}, 64'd4);
    f_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fq_order", {56'd0, f_rdata}, 64'hA3 + 64'(i));
      step();
    end
    chk("fq_empty", {61'd0, f_count}, 64'd0);
    f_pop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nnrv_fetch_queue.md
NNRV_FETCH_QUEUE -- requirements
Module: nnrv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, address and PC width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory read data width; multiple of 32, at least 32.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-004 SHALL have parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 SHALL have port i_clk, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port o_mem_req, output, 1, fetch request valid.
REQ-009 SHALL have port o_mem_addr, output, XLEN, fetch address, always 4-byte aligned.
REQ-010 SHALL have port i_mem_gnt, input, 1, request accepted this cycle.
REQ-011 SHALL have port i_mem_rvalid, input, 1, read data valid.
REQ-012 SHALL have port i_mem_rdata, input, DATA_WIDTH, read data.
REQ-013 SHALL have port o_id_valid, output, 1, queue head holds a valid instruction.
REQ-014 SHALL have port o_id_instr, output, INSTR_WIDTH, head instruction.
REQ-015 SHALL have port o_id_pc, output, XLEN, head instruction PC.
REQ-016 SHALL have port i_id_ready, input, 1, decode consumes the head when o_id_valid is also high.
REQ-017 SHALL have port i_redirect, input, 1, jump/branch redirect.
REQ-018 SHALL have port i_redirect_pc, input, XLEN, redirect target; bits [1:0] are ignored.

Function
REQ-019 SHALL hold fetch PC register pc; o_mem_addr = pc.
REQ-020 SHALL use three states, IDLE, WAIT and DROP, with at most one outstanding request.
REQ-021 IDLE: o_mem_req=1 iff queue count + 0 < DEPTH and i_redirect=0; on i_mem_gnt, pc <= pc+4 and the state goes to WAIT, latching the request address.
REQ-022 WAIT: o_mem_req=0; on i_mem_rvalid, SHALL push {instr slice, latched address} and go to IDLE.
REQ-023 Instr slice SHALL be i_mem_rdata bits [32*k +: INSTR_WIDTH], where k = address[log2(DATA_WIDTH/8)-1:2]; k=0 when DATA_WIDTH=32.
REQ-024 i_mem_rvalid in IDLE SHALL be ignored; a request SHALL be issued only if a queue slot is guaranteed on return.
REQ-025 Pop SHALL occur when o_id_valid and i_id_ready; push and pop in the same cycle SHALL leave the count unchanged, including when the queue is full.
REQ-026 Queue SHALL be a circular buffer with wrapping read/write pointers; o_id_valid = (count != 0); head outputs are don't-care when empty.
REQ-027 Latency: gnt in cycle N, rvalid in cycle N+1 -> o_id_valid high in N+2 if the queue was empty.
REQ-028 On i_redirect: SHALL flush the queue (count=0, o_id_valid=0 next cycle), set pc <= {i_redirect_pc[XLEN-1:2], 2'b00}, and not push that cycle.
REQ-029 Redirect in WAIT without rvalid, or in IDLE coincident with gnt: SHALL go to DROP; DROP discards the next i_mem_rvalid, then goes to IDLE; o_mem_req=0 in DROP.
REQ-030 Redirect in WAIT coincident with rvalid SHALL discard the data and go to IDLE.
REQ-031 Redirect in DROP SHALL update pc and stay in DROP.
REQ-032 Redirect SHALL take priority over pop; a pop in the redirect cycle is ignored.
REQ-033 Arithmetic SHALL wrap modulo 2^XLEN; count SHALL be clog2(DEPTH)+1 bits.

Reset
REQ-034 On i_rst, without waiting for a clock edge: pc=RESET_PC, state=IDLE, queue empty, o_id_valid=0; o_mem_req is combinational from state and count, so it reads 1 once reset releases.
REQ-035 Reset mid-request SHALL abandon the request; a later rvalid SHALL be ignored in IDLE.

Structure
REQ-036 State encoding (IDLE/WAIT/DROP) and default parameter values SHALL live in shared package nnrv_pkg.
REQ-037 The queue SHALL be a sub-module nnrv_fifo (parameters WIDTH, DEPTH; push/pop/flush/count) reusable elsewhere in the core.

Verification
REQ-038 Reset release, gnt=1 each cycle, rvalid one cycle later -> addresses 0x0, 0x4, 0x8, ... with each request issued after the previous response; instr from rdata[31:0] at 0x0 and rdata[63:32] at 0x4.
REQ-039 i_id_ready=0, DEPTH=4 -> exactly 4 pushes, then o_mem_req stays 0; raising i_id_ready resumes fetch at 0x10.
REQ-040 Redirect to 0x100 while in WAIT -> the late rvalid is discarded, the next request is 0x100, and the first o_id_pc is 0x100.
REQ-041 Redirect to 0x206 coincident with a pop -> queue empty next cycle, fetch at 0x204.
REQ-042 Full queue with simultaneous push and pop -> count stays at 4 and instructions emerge in order with no loss.
REQ-043 i_rst asserted in WAIT, rvalid arrives after release -> response ignored, first fetch at RESET_PC.
